// File: rtl/spi_arbiter_pkg.sv
// Shared widths, FSM encoding and defaults for the SPI master arbiter.
package spi_arbiter_pkg;

   localparam int unsigned DATA_W                 = 32;
   localparam int unsigned BITS_W                 = 6;
   localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 4096;

   typedef enum logic [2:0] {
      StIdle,
      StIssue,
      StWaitBusy,
      StWaitDone,
      StRespond
   } state_t;

endpackage

// File: rtl/spi_rr_select.sv
// Combinational round-robin pick: first set req bit at ptr, ptr+1, ... with wrap-around.
module spi_rr_select
   import spi_arbiter_pkg::*;
#(
   parameter int unsigned N_REQ = 4,
   localparam int unsigned PTR_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N_REQ-1:0] grant_next,
   output logic             valid
);

   logic [PTR_W-1:0] idx;
   logic             found;

   always_comb begin
      grant_next = '0;
      found      = 1'b0;
      idx        = '0;
      for (int i = 0; i < N_REQ; i++) begin
         idx = PTR_W'((int'(ptr) + i) % N_REQ);
         if (!found && req[idx]) begin
            grant_next[idx] = 1'b1;
            found           = 1'b1;
         end
      end
   end

   assign valid = |req;

endmodule

// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one SPI master among N_REQ requesters.
// Define SPI_ARBITER_TIMEOUT_EN to build the per-transaction watchdog abort.
module spi_arbiter
   import spi_arbiter_pkg::*;
#(
   parameter int unsigned N_REQ          = 4,
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [N_REQ-1:0]        req,
   input  logic [DATA_W*N_REQ-1:0] req_data_out,
   input  logic [BITS_W*N_REQ-1:0] req_write_bits,
   input  logic [BITS_W*N_REQ-1:0] req_read_bits,
   output logic [N_REQ-1:0]        grant,
   output logic [N_REQ-1:0]        done,
   output logic [DATA_W-1:0]       rd_data,
   output logic                    timeout_err,
   output logic [DATA_W-1:0]       spi_data_out,
   output logic [BITS_W-1:0]       spi_write_bits,
   output logic [BITS_W-1:0]       spi_read_bits,
   output logic                    spi_request,
   input  logic                    spi_busy,
   input  logic [DATA_W-1:0]       spi_data_in
);

   localparam int unsigned PTR_W = $clog2(N_REQ);

   if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
      $error("spi_arbiter: unsupported parameter value");
   end

   state_t             state;
   logic [PTR_W-1:0]   ptr;
   logic [PTR_W-1:0]   owner;
   logic [N_REQ-1:0]   grant_next;
   logic               sel_valid;
   logic [PTR_W-1:0]   sel_idx;
   logic [DATA_W-1:0]  sel_data;
   logic [BITS_W-1:0]  sel_wb;
   logic [BITS_W-1:0]  sel_rb;

   spi_rr_select #(
      .N_REQ (N_REQ)
   ) u_rr_select (
      .req        (req),
      .ptr        (ptr),
      .grant_next (grant_next),
      .valid      (sel_valid)
   );

   always_comb begin
      sel_idx  = '0;
      sel_data = '0;
      sel_wb   = '0;
      sel_rb   = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (grant_next[k]) begin
            sel_idx  = PTR_W'(k);
            sel_data = req_data_out[k*DATA_W +: DATA_W];
            sel_wb   = req_write_bits[k*BITS_W +: BITS_W];
            sel_rb   = req_read_bits[k*BITS_W +: BITS_W];
         end
      end
   end

`ifdef SPI_ARBITER_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] wd_cnt;
   logic             wd_expired;
   assign wd_expired = (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   assign timeout_err = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= StIdle;
         ptr            <= '0;
         owner          <= '0;
         grant          <= '0;
         done           <= '0;
         rd_data        <= '0;
         spi_request    <= 1'b0;
         spi_data_out   <= '0;
         spi_write_bits <= '0;
         spi_read_bits  <= '0;
`ifdef SPI_ARBITER_TIMEOUT_EN
         timeout_err    <= 1'b0;
         wd_cnt         <= '0;
`endif
      end else begin
         done        <= '0;
         spi_request <= 1'b0;
         case (state)
            StIdle: begin
               if (sel_valid && !spi_busy) begin
                  grant          <= grant_next;
                  owner          <= sel_idx;
                  spi_data_out   <= sel_data;
                  spi_write_bits <= sel_wb;
                  spi_read_bits  <= sel_rb;
                  state          <= StIssue;
               end
            end
            StIssue: begin
               spi_request <= 1'b1;
               state       <= StWaitBusy;
`ifdef SPI_ARBITER_TIMEOUT_EN
               wd_cnt      <= '0;
`endif
            end
            StWaitBusy: begin
               if (spi_busy) state <= StWaitDone;
`ifdef SPI_ARBITER_TIMEOUT_EN
               wd_cnt <= wd_cnt + CNT_W'(1);
               if (wd_expired) begin
                  done        <= grant;
                  rd_data     <= '0;
                  timeout_err <= 1'b1;
                  state       <= StRespond;
               end
`endif
            end
            StWaitDone: begin
               // done is registered here so it lands one cycle after spi_busy falls
               if (!spi_busy) begin
                  rd_data <= spi_data_in;
                  done    <= grant;
                  state   <= StRespond;
               end
`ifdef SPI_ARBITER_TIMEOUT_EN
               else begin
                  wd_cnt <= wd_cnt + CNT_W'(1);
                  if (wd_expired) begin
                     done        <= grant;
                     rd_data     <= '0;
                     timeout_err <= 1'b1;
                     state       <= StRespond;
                  end
               end
`endif
            end
            StRespond: begin
               grant <= '0;
               ptr   <= (owner == PTR_W'(N_REQ - 1)) ? '0 : owner + PTR_W'(1);
               state <= StIdle;
`ifdef SPI_ARBITER_TIMEOUT_EN
               timeout_err <= 1'b0;
`endif
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed self-checking bench for spi_arbiter with a small behavioural SPI master.
module tb_spi_arbiter;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic [3:0]   req = '0;
   logic [127:0] req_data_out = '0;
   logic [23:0]  req_write_bits = '0;
   logic [23:0]  req_read_bits = '0;
   logic [3:0]   grant;
   logic [3:0]   done;
   logic [31:0]  rd_data;
   logic         timeout_err;
   logic [31:0]  spi_data_out;
   logic [5:0]   spi_write_bits;
   logic [5:0]   spi_read_bits;
   logic         spi_request;
   logic         spi_busy = 1'b0;
   logic [31:0]  spi_data_in = '0;

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;

   // SPI master model controls and observations
   int          busy_len = 3;
   logic [31:0] model_rd = '0;
   bit          stuck = 1'b0;
   int          req_cyc = 0;
   int          fall_cyc = 0;
   logic [31:0] seen_data = '0;
   logic [5:0]  seen_wb = '0;
   logic [5:0]  seen_rb = '0;

   int req_hi = 0;
   int done_cnt = 0;
   bit grant_multi = 1'b0;

   spi_arbiter #(
      .N_REQ          (4),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .req            (req),
      .req_data_out   (req_data_out),
      .req_write_bits (req_write_bits),
      .req_read_bits  (req_read_bits),
      .grant          (grant),
      .done           (done),
      .rd_data        (rd_data),
      .timeout_err    (timeout_err),
      .spi_data_out   (spi_data_out),
      .spi_write_bits (spi_write_bits),
      .spi_read_bits  (spi_read_bits),
      .spi_request    (spi_request),
      .spi_busy       (spi_busy),
      .spi_data_in    (spi_data_in)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if ($countones(grant) > 1) grant_multi = 1'b1;
      if (done != 4'b0000) done_cnt++;
      if (spi_request === 1'b1) req_hi++;
   end

   always begin
      @(negedge clk);
      if (spi_request === 1'b1) begin
         req_cyc   = cyc;
         seen_data = spi_data_out;
         seen_wb   = spi_write_bits;
         seen_rb   = spi_read_bits;
         spi_busy  = 1'b1;
         repeat (busy_len) @(negedge clk);
         while (stuck) @(negedge clk);
         spi_data_in = model_rd;
         spi_busy    = 1'b0;
         fall_cyc    = cyc;
      end
   end

   task automatic wait_grant(output logic [3:0] g, output int gc, output bit ok);
      ok = 1'b0; g = '0; gc = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (grant !== 4'b0000) begin
            g = grant; gc = cyc; ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_done(output logic [3:0] d, output logic [31:0] rd, output logic to,
                            output int dc, output bit ok);
      ok = 1'b0; d = '0; rd = '0; to = 1'b0; dc = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (done !== 4'b0000) begin
            d = done; rd = rd_data; to = timeout_err; dc = cyc; ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      n_vec++; if (grant !== 4'b0) begin n_err++; $display("FAIL rst_grant: got %b want 0000", grant); end
      n_vec++; if (done !== 4'b0) begin n_err++; $display("FAIL rst_done: got %b want 0000", done); end
      n_vec++; if (spi_request !== 1'b0) begin n_err++; $display("FAIL rst_spi_request: got %b want 0", spi_request); end
      n_vec++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL rst_timeout_err: got %b want 0", timeout_err); end
      n_vec++; if (rd_data !== 32'h0) begin n_err++; $display("FAIL rst_rd_data: got %h want 0", rd_data); end
      n_vec++; if (spi_data_out !== 32'h0) begin n_err++; $display("FAIL rst_spi_data_out: got %h want 0", spi_data_out); end
      n_vec++; if (spi_write_bits !== 6'd0) begin n_err++; $display("FAIL rst_write_bits: got %0d want 0", spi_write_bits); end
      n_vec++; if (spi_read_bits !== 6'd0) begin n_err++; $display("FAIL rst_read_bits: got %0d want 0", spi_read_bits); end
      reset = 1'b0;
      @(negedge clk);
      n_vec++; if (grant !== 4'b0) begin n_err++; $display("FAIL idle_grant: got %b want 0000", grant); end
   endtask

   task automatic test_single();
      logic [3:0] g, d; logic [31:0] rd; logic to; int gc, dc, r0; bit ok;
      req_data_out[31:0] = 32'hA500_0000;
      req_write_bits[5:0] = 6'd16;
      req_read_bits[5:0] = 6'd8;
      model_rd = 32'h0000_00C3;
      busy_len = 3;
      r0 = req_hi;
      req = 4'b0001;
      wait_grant(g, gc, ok);
      n_vec++; if (!ok || g !== 4'b0001) begin n_err++; $display("FAIL single_grant: got %b want 0001", g); end
      wait_done(d, rd, to, dc, ok);
      n_vec++; if (!ok || d !== 4'b0001) begin n_err++; $display("FAIL single_done: got %b want 0001", d); end
      n_vec++; if (rd !== 32'h0000_00C3) begin n_err++; $display("FAIL single_rd_data: got %h want 000000c3", rd); end
      n_vec++; if (to !== 1'b0) begin n_err++; $display("FAIL single_timeout_err: got %b want 0", to); end
      n_vec++; if (req_cyc !== gc + 1) begin n_err++; $display("FAIL single_req_latency: got %0d want %0d", req_cyc - gc, 1); end
      n_vec++; if (dc !== fall_cyc + 1) begin n_err++; $display("FAIL single_done_latency: got %0d want %0d", dc - fall_cyc, 1); end
      n_vec++; if (seen_data !== 32'hA500_0000) begin n_err++; $display("FAIL single_payload: got %h want a5000000", seen_data); end
      n_vec++; if (seen_wb !== 6'd16 || seen_rb !== 6'd8) begin n_err++; $display("FAIL single_bits: got %0d/%0d want 16/8", seen_wb, seen_rb); end
      n_vec++; if (req_hi - r0 !== 1) begin n_err++; $display("FAIL single_req_width: got %0d want 1", req_hi - r0); end
      req = 4'b0000;
      @(negedge clk);
      n_vec++; if (done !== 4'b0 || grant !== 4'b0) begin n_err++; $display("FAIL single_after: got done %b grant %b want 0000 0000", done, grant); end
      n_vec++; if (rd_data !== 32'h0000_00C3) begin n_err++; $display("FAIL single_rd_hold: got %h want 000000c3", rd_data); end
   endtask

   task automatic test_round_robin();
      logic [3:0] g, d, exp_g; logic [31:0] rd, exp_rd; logic to; int gc, dc, prev_dc; bit ok;
      int ord[5] = '{0, 1, 2, 3, 0};
      @(negedge clk); reset = 1'b1;
      @(negedge clk); reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         req_data_out[32*k +: 32] = 32'hD000_0000 + k;
         req_write_bits[6*k +: 6] = 6'(8 + k);
         req_read_bits[6*k +: 6] = 6'(4 + k);
      end
      busy_len = 2;
      prev_dc = 0;
      req = 4'b1111;
      for (int t = 0; t < 5; t++) begin
         exp_rd = 32'h5500_0000 + t;
         model_rd = exp_rd;
         exp_g = 4'b0001 << ord[t];
         wait_grant(g, gc, ok);
         n_vec++; if (!ok || g !== exp_g) begin n_err++; $display("FAIL rr_grant[%0d]: got %b want %b", t, g, exp_g); end
         if (t > 0) begin
            n_vec++; if (gc !== prev_dc + 2) begin n_err++; $display("FAIL rr_gap[%0d]: got %0d want 2", t, gc - prev_dc); end
         end
         wait_done(d, rd, to, dc, ok);
         n_vec++; if (!ok || d !== exp_g) begin n_err++; $display("FAIL rr_done[%0d]: got %b want %b", t, d, exp_g); end
         n_vec++; if (rd !== exp_rd) begin n_err++; $display("FAIL rr_rd_data[%0d]: got %h want %h", t, rd, exp_rd); end
         n_vec++; if (seen_data !== 32'hD000_0000 + ord[t]) begin n_err++; $display("FAIL rr_payload[%0d]: got %h want %h", t, seen_data, 32'hD000_0000 + ord[t]); end
         prev_dc = dc;
      end
      req = 4'b0000;
      @(negedge clk);
   endtask

   task automatic test_payload_stable();
      logic [3:0] g, d; logic [31:0] rd; logic to; int gc, dc; bit ok;
      req_data_out[95:64] = 32'h1234_5678;
      req_write_bits[17:12] = 6'd20;
      req_read_bits[17:12] = 6'd12;
      busy_len = 6;
      model_rd = 32'hBEEF_0002;
      req = 4'b0100;
      wait_grant(g, gc, ok);
      n_vec++; if (!ok || g !== 4'b0100) begin n_err++; $display("FAIL stable_grant: got %b want 0100", g); end
      repeat (3) @(negedge clk);
      req_data_out[95:64] = 32'hFFFF_0000;
      req_write_bits[17:12] = 6'd1;
      req = 4'b0000;
      @(negedge clk);
      n_vec++; if (spi_data_out !== 32'h1234_5678) begin n_err++; $display("FAIL stable_data: got %h want 12345678", spi_data_out); end
      n_vec++; if (spi_write_bits !== 6'd20 || spi_read_bits !== 6'd12) begin n_err++; $display("FAIL stable_bits: got %0d/%0d want 20/12", spi_write_bits, spi_read_bits); end
      wait_done(d, rd, to, dc, ok);
      n_vec++; if (!ok || d !== 4'b0100) begin n_err++; $display("FAIL stable_done: got %b want 0100", d); end
      n_vec++; if (rd !== 32'hBEEF_0002) begin n_err++; $display("FAIL stable_rd_data: got %h want beef0002", rd); end
   endtask

   task automatic test_wrap_and_drop();
      logic [3:0] g, d; logic [31:0] rd; logic to; int gc, dc; bit ok;
      busy_len = 2;
      model_rd = 32'h0000_0003;
      req = 4'b1001;
      wait_grant(g, gc, ok);
      n_vec++; if (!ok || g !== 4'b1000) begin n_err++; $display("FAIL wrap_first: got %b want 1000", g); end
      wait_done(d, rd, to, dc, ok);
      n_vec++; if (!ok || d !== 4'b1000 || rd !== 32'h3) begin n_err++; $display("FAIL wrap_done3: got %b %h want 1000 00000003", d, rd); end
      req = 4'b0001;
      model_rd = 32'h0000_0011;
      wait_grant(g, gc, ok);
      n_vec++; if (!ok || g !== 4'b0001) begin n_err++; $display("FAIL wrap_second: got %b want 0001", g); end
      n_vec++; if (gc !== dc + 2) begin n_err++; $display("FAIL wrap_gap: got %0d want 2", gc - dc); end
      req = 4'b0011;
      wait_done(d, rd, to, dc, ok);
      n_vec++; if (!ok || d !== 4'b0001 || rd !== 32'h11) begin n_err++; $display("FAIL wrap_done0: got %b %h want 0001 00000011", d, rd); end
      // requester 1 would win next but withdraws before being granted
      req = 4'b0100;
      model_rd = 32'h0000_0022;
      wait_grant(g, gc, ok);
      n_vec++; if (!ok || g !== 4'b0100) begin n_err++; $display("FAIL drop_grant: got %b want 0100", g); end
      wait_done(d, rd, to, dc, ok);
      n_vec++; if (!ok || d !== 4'b0100) begin n_err++; $display("FAIL drop_done: got %b want 0100", d); end
      req = 4'b0000;
   endtask

   task automatic test_reset_mid();
      logic [3:0] g, d; logic [31:0] rd; logic to; int gc, dc, d0; bit ok;
      req_data_out[63:32] = 32'h0F0F_0F0F;
      req_write_bits[11:6] = 6'd9;
      req_read_bits[11:6] = 6'd5;
      busy_len = 10;
      req = 4'b0010;
      wait_grant(g, gc, ok);
      n_vec++; if (!ok || g !== 4'b0010) begin n_err++; $display("FAIL rmid_grant: got %b want 0010", g); end
      repeat (4) @(negedge clk);
      d0 = done_cnt;
      reset = 1'b1;
      #1;
      n_vec++; if (grant !== 4'b0 || done !== 4'b0) begin n_err++; $display("FAIL rmid_grant_done: got %b %b want 0000 0000", grant, done); end
      n_vec++; if (spi_request !== 1'b0 || timeout_err !== 1'b0) begin n_err++; $display("FAIL rmid_strobes: got %b %b want 0 0", spi_request, timeout_err); end
      n_vec++; if (rd_data !== 32'h0 || spi_data_out !== 32'h0) begin n_err++; $display("FAIL rmid_data: got %h %h want 0 0", rd_data, spi_data_out); end
      n_vec++; if (spi_write_bits !== 6'd0 || spi_read_bits !== 6'd0) begin n_err++; $display("FAIL rmid_bits: got %0d %0d want 0 0", spi_write_bits, spi_read_bits); end
      req = 4'b0000;
      @(negedge clk);
      reset = 1'b0;
      repeat (12) @(negedge clk);
      n_vec++; if (done_cnt !== d0) begin n_err++; $display("FAIL rmid_no_done: got %0d pulses want 0", done_cnt - d0); end
      model_rd = 32'h0000_00A1;
      busy_len = 2;
      req = 4'b1010;
      wait_grant(g, gc, ok);
      n_vec++; if (!ok || g !== 4'b0010) begin n_err++; $display("FAIL rmid_ptr0: got %b want 0010", g); end
      wait_done(d, rd, to, dc, ok);
      n_vec++; if (!ok || d !== 4'b0010 || rd !== 32'hA1) begin n_err++; $display("FAIL rmid_after: got %b %h want 0010 000000a1", d, rd); end
      req = 4'b0000;
   endtask

   task automatic test_timeout();
      logic [3:0] g, d; logic [31:0] rd; logic to; int gc, dc; bit ok;
      stuck = 1'b1;
      busy_len = 1;
      model_rd = 32'h0000_7777;
      req = 4'b0001;
      wait_grant(g, gc, ok);
      n_vec++; if (!ok || g !== 4'b0001) begin n_err++; $display("FAIL to_grant: got %b want 0001", g); end
`ifdef SPI_ARBITER_TIMEOUT_EN
      wait_done(d, rd, to, dc, ok);
      n_vec++; if (!ok || d !== 4'b0001 || to !== 1'b1) begin n_err++; $display("FAIL to_abort: got %b %b want 0001 1", d, to); end
      n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL to_rd_data: got %h want 0", rd); end
      n_vec++; if (dc !== gc + 17) begin n_err++; $display("FAIL to_latency: got %0d want 16", dc - gc - 1); end
      req = 4'b0000;
      @(negedge clk);
      n_vec++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL to_clear: got %b want 0", timeout_err); end
      stuck = 1'b0;
      repeat (4) @(negedge clk);
`else
      dc = done_cnt;
      repeat (40) @(negedge clk);
      n_vec++; if (done_cnt !== dc || grant !== 4'b0001) begin n_err++; $display("FAIL to_wait: got %0d pulses grant %b want 0 0001", done_cnt - dc, grant); end
      n_vec++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL to_tied: got %b want 0", timeout_err); end
      stuck = 1'b0;
      wait_done(d, rd, to, dc, ok);
      n_vec++; if (!ok || d !== 4'b0001 || to !== 1'b0) begin n_err++; $display("FAIL to_complete: got %b %b want 0001 0", d, to); end
      n_vec++; if (rd !== 32'h0000_7777) begin n_err++; $display("FAIL to_rd_data: got %h want 00007777", rd); end
      req = 4'b0000;
      @(negedge clk);
`endif
   endtask

   task automatic test_grant_onehot();
      n_vec++; if (grant_multi !== 1'b0) begin n_err++; $display("FAIL grant_onehot: got multi-bit grant want one-hot"); end
      n_vec++; if (done_cnt !== 12) begin n_err++; $display("FAIL done_pulses: got %0d want 12", done_cnt); end
   endtask

   initial begin
      #1 reset = 1'b1;
      test_reset();
      test_single();
      test_round_robin();
      test_payload_stable();
      test_wrap_and_drop();
      test_reset_mid();
      test_timeout();
      test_grant_onehot();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
